hazard_ctrl: RTL and testbench

Hazard and forwarding controller for the 5-stage pipelined MIPS core.
- Generates the 2-bit select codes for the E-stage source-operand forwarding muxes and the 1-bit D-stage branch-compare forwarding selects.
- Generates stall_F/stall_D/flush_D/flush_E for load-use, branch-operand and multi-cycle mul/div hazards.
- Owns the only sequential state in hazard resolution: a mul/div busy countdown.

---
 rtl/mips_hazard_pkg.sv | 27 ++
 rtl/md_busy_counter.sv | 47 ++++
 rtl/hazard_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_hazard_pkg
// Description : Shared constants and types for the MIPS hazard / forwarding
//               controller. Holds the forward-mux select encoding, the
//               hard-wired zero register specifier and the width of the
//               mul/div busy countdown.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_hazard_pkg;

  // Select encoding shared by the E-stage operand forwarding muxes.
  // Code 2'b11 is never produced by the controller.
  typedef enum logic [1:0] {
    FWD_RF = 2'b00,  // register-file read data
    FWD_W  = 2'b01,  // result_W
    FWD_M  = 2'b10   // aluout_M
  } fwd_sel_e;

  // Register $0 is hard-wired to zero: it never forwards and never stalls.
  localparam int REG_ZERO = 0;

  // Width of the mul/div busy countdown. Holds MD_CYCLES values of 1..15.
  localparam int MD_CNT_W = 4;

endpackage : mips_hazard_pkg
`default_nettype wire

// File: rtl/md_busy_counter.sv
`default_nettype none
// ============================================================================
// Module      : md_busy_counter
// Description : Busy tracker for the multi-cycle HI/LO mul/div unit. A start
//               pulse (re)loads LOAD_VAL; the count then decrements once per
//               clock until it reaches zero and stays there. A start while
//               already busy restarts the countdown rather than adding to it.
// Revision    : 1.0 - initial release
//
// Ports:
//   clk      in   core clock
//   reset_n  in   asynchronous active-low reset, clears the count at once
//   start    in   mul/div issued in E this cycle (single-cycle pulse)
//   busy     out  unit busy, derived purely from the registered count
// ============================================================================
module md_busy_counter
  import mips_hazard_pkg::*;
#(
  parameter int CNT_W    = MD_CNT_W,
  parameter int LOAD_VAL = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  output logic busy
);

  localparam logic [CNT_W-1:0] c_load = CNT_W'(LOAD_VAL);
  localparam logic [CNT_W-1:0] c_one  = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (start) begin
      r_cnt <= c_load;
    end else if (r_cnt != '0) begin
      // Guarded decrement: the count saturates at zero.
      r_cnt <= r_cnt - c_one;
    end
  end

  assign busy = (r_cnt != '0);

endmodule : md_busy_counter
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Hazard and forwarding controller for the 5-stage pipelined
//               MIPS core. Produces the E-stage operand forward selects, the
//               D-stage branch-compare forward selects and the stall / flush
//               controls for load-use, branch-operand and mul/div hazards.
//               All control outputs are combinational; the only state is the
//               mul/div busy countdown (md_busy_counter).
// Revision    : 1.0 - initial release
//
// Build option:
//   HAZARD_STATS_EN  when defined, adds saturating 32-bit stall_cycles and
//                    flush_cycles counters as outputs.
//
// Ports:
//   clk, reset_n                        clock, async active-low reset
//   rs_D, rt_D                          D-stage source specifiers
//   rs_E, rt_E                          E-stage source specifiers
//   writereg_E/_M/_W, regwrite_E/_M/_W  destination and write-valid per stage
//   memtoreg_E, memtoreg_M              load in E / M
//   branch_D, pcsrc_D                   branch in D, branch taken
//   md_use_D, md_start_E                mul/div consumer in D, start in E
//   forward_a_E, forward_b_E            E forward selects (FWD_* codes)
//   forward_a_D, forward_b_D            D compare select (1 = aluout_M)
//   stall_F, stall_D, flush_D, flush_E  pipeline register controls
//   md_busy                             mul/div unit busy
//   stall_cycles, flush_cycles          statistics (HAZARD_STATS_EN only)
// ============================================================================
module hazard_ctrl
  import mips_hazard_pkg::*;
#(
  parameter int N_REG_BITS = 5,
  parameter int MD_CYCLES  = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [N_REG_BITS-1:0] rs_D,
  input  logic [N_REG_BITS-1:0] rt_D,
  input  logic [N_REG_BITS-1:0] rs_E,
  input  logic [N_REG_BITS-1:0] rt_E,
  input  logic [N_REG_BITS-1:0] writereg_E,
  input  logic [N_REG_BITS-1:0] writereg_M,
  input  logic [N_REG_BITS-1:0] writereg_W,
  input  logic                  regwrite_E,
  input  logic                  regwrite_M,
  input  logic                  regwrite_W,
  input  logic                  memtoreg_E,
  input  logic                  memtoreg_M,
  input  logic                  branch_D,
  input  logic                  pcsrc_D,
  input  logic                  md_use_D,
  input  logic                  md_start_E,
  output logic [1:0]            forward_a_E,
  output logic [1:0]            forward_b_E,
  output logic                  forward_a_D,
  output logic                  forward_b_D,
  output logic                  stall_F,
  output logic                  stall_D,
  output logic                  flush_D,
  output logic                  flush_E,
`ifdef HAZARD_STATS_EN
  output logic [31:0]           stall_cycles,
  output logic [31:0]           flush_cycles,
`endif
  output logic                  md_busy
);

  localparam logic [N_REG_BITS-1:0] c_zero = N_REG_BITS'(REG_ZERO);

  // --------------------------------------------------------------------------
  // E-stage operand forwarding. M has priority over W because it holds the
  // younger (more recent) write to the same register.
  // --------------------------------------------------------------------------
  fwd_sel_e w_fwd_a_e;
  fwd_sel_e w_fwd_b_e;

  always_comb begin
    w_fwd_a_e = FWD_RF;
    if (rs_E != c_zero && regwrite_M && rs_E == writereg_M) begin
      w_fwd_a_e = FWD_M;
    end else if (rs_E != c_zero && regwrite_W && rs_E == writereg_W) begin
      w_fwd_a_e = FWD_W;
    end
  end

  always_comb begin
    w_fwd_b_e = FWD_RF;
    if (rt_E != c_zero && regwrite_M && rt_E == writereg_M) begin
      w_fwd_b_e = FWD_M;
    end else if (rt_E != c_zero && regwrite_W && rt_E == writereg_W) begin
      w_fwd_b_e = FWD_W;
    end
  end

  // D-stage branch comparator can only take aluout_M; W results are already
  // visible through the write-first register file.
  logic w_fwd_a_d;
  logic w_fwd_b_d;

  assign w_fwd_a_d = (rs_D != c_zero) && regwrite_M && (rs_D == writereg_M);
  assign w_fwd_b_d = (rt_D != c_zero) && regwrite_M && (rt_D == writereg_M);

  // --------------------------------------------------------------------------
  // Hazard detection
  // --------------------------------------------------------------------------
  logic w_md_busy;
  logic w_lwstall;
  logic w_brstall;
  logic w_mdstall;
  logic w_stall;
  logic w_br_hit_e;
  logic w_br_hit_m;

  // Load in E whose destination (rt_E) feeds the instruction in D.
  assign w_lwstall = memtoreg_E && regwrite_E && (rt_E != c_zero) &&
                     ((rt_E == rs_D) || (rt_E == rt_D));

  // A branch compares in D, so an ALU result still in E, or load data still
  // in M, cannot reach the comparator yet.
  assign w_br_hit_e = regwrite_E && (writereg_E != c_zero) &&
                      ((writereg_E == rs_D) || (writereg_E == rt_D));
  assign w_br_hit_m = memtoreg_M && (writereg_M != c_zero) &&
                      ((writereg_M == rs_D) || (writereg_M == rt_D));
  assign w_brstall  = branch_D && (w_br_hit_e || w_br_hit_m);

  // A start in E this cycle counts as busy even though the count loads on
  // the coming edge.
  assign w_mdstall = md_use_D && (w_md_busy || md_start_E);

  assign w_stall = w_lwstall || w_brstall || w_mdstall;

  // --------------------------------------------------------------------------
  // Mul/div busy countdown
  // --------------------------------------------------------------------------
  md_busy_counter #(
    .CNT_W    (MD_CNT_W),
    .LOAD_VAL (MD_CYCLES)
  ) u_md_busy_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (md_start_E),
    .busy    (w_md_busy)
  );

  // --------------------------------------------------------------------------
  // Outputs. Everything is forced inactive while reset_n is low so the
  // pipeline sees no forwarding or stalls before it is released.
  // --------------------------------------------------------------------------
  assign forward_a_E = reset_n ? w_fwd_a_e : FWD_RF;
  assign forward_b_E = reset_n ? w_fwd_b_e : FWD_RF;
  assign forward_a_D = reset_n && w_fwd_a_d;
  assign forward_b_D = reset_n && w_fwd_b_d;
  assign stall_F     = reset_n && w_stall;
  assign stall_D     = reset_n && w_stall;
  assign flush_E     = reset_n && w_stall;
  // A stall holds the branch in D, so it must not be flushed that cycle.
  assign flush_D     = reset_n && pcsrc_D && !w_stall;
  assign md_busy     = reset_n && w_md_busy;

`ifdef HAZARD_STATS_EN
  // --------------------------------------------------------------------------
  // Saturating statistics counters
  // --------------------------------------------------------------------------
  logic [31:0] r_stall_cycles;
  logic [31:0] r_flush_cycles;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_cycles <= '0;
      r_flush_cycles <= '0;
    end else begin
      if (stall_D && (r_stall_cycles != 32'hFFFF_FFFF)) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
      if (flush_D && (r_flush_cycles != 32'hFFFF_FFFF)) begin
        r_flush_cycles <= r_flush_cycles + 32'd1;
      end
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_cycles = r_flush_cycles;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule : hazard_ctrl
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Self-checking bench for hazard_ctrl (MD_CYCLES = 4). Each
//               scenario task drives inputs just after a rising edge, pushes
//               the expected output vector to a scoreboard queue, and pops /
//               compares it on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [4:0] rs_D, rt_D, rs_E, rt_E;
  logic [4:0] writereg_E, writereg_M, writereg_W;
  logic       regwrite_E, regwrite_M, regwrite_W;
  logic       memtoreg_E, memtoreg_M;
  logic       branch_D, pcsrc_D, md_use_D, md_start_E;
  logic [1:0] forward_a_E, forward_b_E;
  logic       forward_a_D, forward_b_D;
  logic       stall_F, stall_D, flush_D, flush_E, md_busy;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cycles, flush_cycles;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard: {fa_E, fb_E, fa_D, fb_D, stall_F, stall_D, flush_E, flush_D, md_busy}
  logic [10:0] sb_q[$];
  logic [10:0] obs;

  assign obs = {forward_a_E, forward_b_E, forward_a_D, forward_b_D,
                stall_F, stall_D, flush_E, flush_D, md_busy};

  always #5 clk = ~clk;

  hazard_ctrl #(
    .N_REG_BITS (5),
    .MD_CYCLES  (4)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .rs_D        (rs_D),
    .rt_D        (rt_D),
    .rs_E        (rs_E),
    .rt_E        (rt_E),
    .writereg_E  (writereg_E),
    .writereg_M  (writereg_M),
    .writereg_W  (writereg_W),
    .regwrite_E  (regwrite_E),
    .regwrite_M  (regwrite_M),
    .regwrite_W  (regwrite_W),
    .memtoreg_E  (memtoreg_E),
    .memtoreg_M  (memtoreg_M),
    .branch_D    (branch_D),
    .pcsrc_D     (pcsrc_D),
    .md_use_D    (md_use_D),
    .md_start_E  (md_start_E),
    .forward_a_E (forward_a_E),
    .forward_b_E (forward_b_E),
    .forward_a_D (forward_a_D),
    .forward_b_D (forward_b_D),
    .stall_F     (stall_F),
    .stall_D     (stall_D),
    .flush_D     (flush_D),
    .flush_E     (flush_E),
`ifdef HAZARD_STATS_EN
    .stall_cycles(stall_cycles),
    .flush_cycles(flush_cycles),
`endif
    .md_busy     (md_busy)
  );

  // Expected-vector constructor; one stall bit covers stall_F/stall_D/flush_E.
  function automatic logic [10:0] ev(input logic [1:0] fa, input logic [1:0] fb,
                                     input logic fad, input logic fbd,
                                     input logic st, input logic fl, input logic bz);
    return {fa, fb, fad, fbd, st, st, st, fl, bz};
  endfunction

  task automatic clr_inputs();
    rs_D = 0; rt_D = 0; rs_E = 0; rt_E = 0;
    writereg_E = 0; writereg_M = 0; writereg_W = 0;
    regwrite_E = 0; regwrite_M = 0; regwrite_W = 0;
    memtoreg_E = 0; memtoreg_M = 0;
    branch_D = 0; pcsrc_D = 0; md_use_D = 0; md_start_E = 0;
  endtask

  task automatic test_reset();
    logic [10:0] e;
    clr_inputs();
    // Hazards everywhere while in reset: all outputs must stay inactive.
    rs_E = 3; writereg_M = 3; regwrite_M = 1;
    memtoreg_E = 1; regwrite_E = 1; rt_E = 5; rs_D = 5;
    pcsrc_D = 1; md_start_E = 1; md_use_D = 1;
    for (int s = 0; s < 3; s++) begin
      if (s == 0) #2;
      else if (s == 1) begin @(posedge clk); #1; end
      else begin
        @(posedge clk); #1;
        clr_inputs(); md_use_D = 1; reset_n = 1'b1;
      end
      sb_q.push_back(ev(2'b00, 2'b00, 0, 0, 0, 0, 0));
      #1;
      e = sb_q.pop_front(); n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL reset step %0d: got %b expected %b", s, obs, e);
      end
    end
  endtask

  task automatic test_forward();
    logic [10:0] e;
    for (int s = 0; s < 8; s++) begin
      @(posedge clk); #1; clr_inputs();
      case (s)
        0: begin rs_E = 3; writereg_M = 3; regwrite_M = 1; writereg_W = 3; regwrite_W = 1;
                 sb_q.push_back(ev(2'b10, 2'b00, 0, 0, 0, 0, 0)); end
        1: begin rs_E = 3; writereg_M = 3; regwrite_M = 0; writereg_W = 3; regwrite_W = 1;
                 sb_q.push_back(ev(2'b01, 2'b00, 0, 0, 0, 0, 0)); end
        2: begin rs_E = 0; writereg_M = 0; regwrite_M = 1; writereg_W = 0; regwrite_W = 1;
                 sb_q.push_back(ev(2'b00, 2'b00, 0, 0, 0, 0, 0)); end
        3: begin rs_E = 4; rt_E = 9; writereg_M = 4; regwrite_M = 1; writereg_W = 9; regwrite_W = 1;
                 sb_q.push_back(ev(2'b10, 2'b01, 0, 0, 0, 0, 0)); end
        4: begin rt_E = 9; writereg_M = 9; regwrite_M = 1; writereg_W = 9; regwrite_W = 1;
                 sb_q.push_back(ev(2'b00, 2'b10, 0, 0, 0, 0, 0)); end
        5: begin rs_D = 6; rt_D = 8; writereg_M = 8; regwrite_M = 1;
                 sb_q.push_back(ev(2'b00, 2'b00, 0, 1, 0, 0, 0)); end
        6: begin rs_D = 8; writereg_M = 8; regwrite_M = 0; writereg_W = 8; regwrite_W = 1;
                 sb_q.push_back(ev(2'b00, 2'b00, 0, 0, 0, 0, 0)); end
        default: begin rs_E = 5; writereg_M = 6; regwrite_M = 1; writereg_W = 5; regwrite_W = 0;
                 sb_q.push_back(ev(2'b00, 2'b00, 0, 0, 0, 0, 0)); end
      endcase
      @(negedge clk);
      e = sb_q.pop_front(); n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL forward step %0d: got %b expected %b", s, obs, e);
      end
    end
  endtask

  task automatic test_loaduse();
    logic [10:0] e;
    for (int s = 0; s < 7; s++) begin
      @(posedge clk); #1; clr_inputs();
      case (s)
        0: begin memtoreg_E = 1; regwrite_E = 1; rt_E = 5; writereg_E = 5; rs_D = 5;
                 sb_q.push_back(ev(2'b00, 2'b00, 0, 0, 1, 0, 0)); end
        1: begin memtoreg_M = 1; regwrite_M = 1; writereg_M = 5; rs_E = 5; rs_D = 1; rt_D = 2;
                 sb_q.push_back(ev(2'b10, 2'b00, 0, 0, 0, 0, 0)); end
        2: begin memtoreg_E = 1; regwrite_E = 1; rt_E = 0;
                 sb_q.push_back(ev(2'b00, 2'b00, 0, 0, 0, 0, 0)); end
        3: begin memtoreg_E = 1; regwrite_E = 1; rt_E = 7; rt_D = 7; rs_D = 3;
                 sb_q.push_back(ev(2'b00, 2'b00, 0, 0, 1, 0, 0)); end
        4: begin memtoreg_E = 1; regwrite_E = 1; rt_E = 7; rt_D = 7; rs_D = 3; pcsrc_D = 1;
                 sb_q.push_back(ev(2'b00, 2'b00, 0, 0, 1, 0, 0)); end
        5: begin memtoreg_E = 1; regwrite_E = 0; rt_E = 7; rs_D = 7;
                 sb_q.push_back(ev(2'b00, 2'b00, 0, 0, 0, 0, 0)); end
        default: begin pcsrc_D = 1;
                 sb_q.push_back(ev(2'b00, 2'b00, 0, 0, 0, 1, 0)); end
      endcase
      @(negedge clk);
      e = sb_q.pop_front(); n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL loaduse step %0d: got %b expected %b", s, obs, e);
      end
    end
  endtask

  task automatic test_branch();
    logic [10:0] e;
    for (int s = 0; s < 7; s++) begin
      @(posedge clk); #1; clr_inputs();
      case (s)
        0: begin branch_D = 1; rs_D = 7; rt_D = 1; writereg_E = 7; regwrite_E = 1;
                 sb_q.push_back(ev(2'b00, 2'b00, 0, 0, 1, 0, 0)); end
        1: begin branch_D = 1; rs_D = 7; rt_D = 1; writereg_M = 7; regwrite_M = 1;
                 writereg_E = 2; regwrite_E = 1;
                 sb_q.push_back(ev(2'b00, 2'b00, 1, 0, 0, 0, 0)); end
        2: begin branch_D = 1; rs_D = 7; rt_D = 1; writereg_M = 7; regwrite_M = 1;
                 writereg_E = 2; regwrite_E = 1; pcsrc_D = 1;
                 sb_q.push_back(ev(2'b00, 2'b00, 1, 0, 0, 1, 0)); end
        3: begin branch_D = 1; rs_D = 4; rt_D = 9; memtoreg_M = 1; regwrite_M = 1;
                 writereg_M = 9; pcsrc_D = 1;
                 sb_q.push_back(ev(2'b00, 2'b00, 0, 1, 1, 0, 0)); end
        4: begin branch_D = 1; writereg_E = 0; regwrite_E = 1; memtoreg_M = 1;
                 regwrite_M = 1; writereg_M = 0;
                 sb_q.push_back(ev(2'b00, 2'b00, 0, 0, 0, 0, 0)); end
        5: begin branch_D = 0; rs_D = 7; writereg_E = 7; regwrite_E = 1;
                 sb_q.push_back(ev(2'b00, 2'b00, 0, 0, 0, 0, 0)); end
        default: begin branch_D = 1; rs_D = 2; rt_D = 6; writereg_E = 6; regwrite_E = 0;
                 sb_q.push_back(ev(2'b00, 2'b00, 0, 0, 0, 0, 0)); end
      endcase
      @(negedge clk);
      e = sb_q.pop_front(); n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL branch step %0d: got %b expected %b", s, obs, e);
      end
    end
  endtask

  // Cycle-by-cycle mul/div timing with MD_CYCLES = 4, including a restart
  // while busy (cycle 9) that must reload rather than accumulate.
  task automatic test_muldiv();
    logic [10:0] e;
    logic [14:0] st_pat, use_pat, busy_pat;
    st_pat   = 15'b000_0010_0100_0001;  // bit i = cycle i
    use_pat  = 15'b100_0000_0011_1111;
    busy_pat = 15'b011_1111_1001_1110;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1; clr_inputs();
      md_start_E = st_pat[c];
      md_use_D   = use_pat[c];
      sb_q.push_back(ev(2'b00, 2'b00, 0, 0,
                        use_pat[c] & (busy_pat[c] | st_pat[c]), 0, busy_pat[c]));
      @(negedge clk);
      e = sb_q.pop_front(); n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL muldiv cycle %0d: got %b expected %b", c, obs, e);
      end
    end
  endtask

  task automatic test_reset_midcount();
    logic [10:0] e;
    @(posedge clk); #1; clr_inputs(); md_start_E = 1;
    @(posedge clk); #1; md_start_E = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;   // count is now 2
    for (int s = 0; s < 5; s++) begin
      case (s)
        0: begin md_use_D = 1;
                 sb_q.push_back(ev(2'b00, 2'b00, 0, 0, 1, 0, 1)); end
        1: begin reset_n = 1'b0; rs_E = 3; writereg_M = 3; regwrite_M = 1;
                 sb_q.push_back(ev(2'b00, 2'b00, 0, 0, 0, 0, 0)); end
        2: begin @(posedge clk); #1;
                 sb_q.push_back(ev(2'b00, 2'b00, 0, 0, 0, 0, 0)); end
        3: begin reset_n = 1'b1; clr_inputs(); md_use_D = 1;
                 sb_q.push_back(ev(2'b00, 2'b00, 0, 0, 0, 0, 0)); end
        default: begin @(posedge clk); #1;
                 sb_q.push_back(ev(2'b00, 2'b00, 0, 0, 0, 0, 0)); end
      endcase
      #1;
      e = sb_q.pop_front(); n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL reset_midcount step %0d: got %b expected %b", s, obs, e);
      end
    end
  endtask

`ifdef HAZARD_STATS_EN
  task automatic test_stats();
    logic [63:0] stq[$];
    logic [63:0] e;
    @(posedge clk); #1; clr_inputs(); reset_n = 1'b0;
    stq.push_back(64'd0);
    #1;
    e = stq.pop_front(); n_checks++;
    if ({stall_cycles, flush_cycles} !== e) begin
      n_fail++;
      $display("FAIL stats_reset: got %0d/%0d expected 0/0", stall_cycles, flush_cycles);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1; clr_inputs();
      memtoreg_E = 1; regwrite_E = 1; rt_E = 5; rs_D = 5;
    end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1; clr_inputs(); pcsrc_D = 1;
    end
    @(posedge clk); #1; clr_inputs();
    stq.push_back({32'd3, 32'd2});
    @(negedge clk);
    e = stq.pop_front();
    n_checks++;
    if (stall_cycles !== e[63:32]) begin
      n_fail++;
      $display("FAIL stall_cycles: got %0d expected %0d", stall_cycles, e[63:32]);
    end
    n_checks++;
    if (flush_cycles !== e[31:0]) begin
      n_fail++;
      $display("FAIL flush_cycles: got %0d expected %0d", flush_cycles, e[31:0]);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_forward();
    test_loaduse();
    test_branch();
    test_muldiv();
    test_reset_midcount();
`ifdef HAZARD_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_hazard_ctrl
`default_nettype wire
